// File: rtl/button_bank_pkg.sv
// Shared types and codes for the multi-channel button front end.
// Debounce FSM state encodings, edge_mode codes and a width helper.
package button_bank_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } deb_state_t;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_ANY  = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    // Bits needed to hold max_val, never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_bank_debounce_fsm.sv
// One button channel: two-flop synchroniser followed by a four-state debounce FSM.
// deb_out changes DEB_TICKS+3 edges after a clean step on the pin; no backpressure.
module debounce_fsm #(
    parameter int DEB_TICKS = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_noisy,
    output logic o_deb
);
    import button_bank_pkg::*;

    localparam int             TW   = width_for(DEB_TICKS - 1);
    localparam logic [TW-1:0]  LOAD = TW'(DEB_TICKS - 1);

    logic          r_sync1;
    logic          r_sync2;
    deb_state_t    r_state;
    logic [TW-1:0] r_timer;
    logic          r_deb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ZERO;
            r_timer <= '0;
            r_deb   <= 1'b0;
        end else begin
            r_sync1 <= i_noisy;
            r_sync2 <= r_sync1;
            case (r_state)
                ZERO: begin
                    if (r_sync2) begin
                        r_state <= WAIT1;
                        r_timer <= LOAD;
                    end
                end
                WAIT1: begin
                    if (!r_sync2) begin
                        r_state <= ZERO;
                    end else if (r_timer == '0) begin
                        r_state <= ONE;
                        r_deb   <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ONE: begin
                    if (!r_sync2) begin
                        r_state <= WAIT0;
                        r_timer <= LOAD;
                    end
                end
                WAIT0: begin
                    if (r_sync2) begin
                        r_state <= ONE;
                    end else if (r_timer == '0) begin
                        r_state <= ZERO;
                        r_deb   <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: r_state <= ZERO;
            endcase
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/button_bank.sv
// CHANNELS debounced buttons with edge select, hold-to-repeat and wrapping event counters.
// pulse is combinational from registered state; counts/overflow update one edge after pulse.
module button_bank #(
    parameter int CHANNELS     = 4,
    parameter int CNT_BITS     = 4,
    parameter int DEB_TICKS    = 1_000_000,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          noisy_in,
    input  logic [1:0]                   edge_mode,
    input  logic                         repeat_en,
    input  logic                         clear,
    output logic [CHANNELS-1:0]          deb_out,
    output logic [CHANNELS-1:0]          pulse,
    output logic [CHANNELS*CNT_BITS-1:0] counts,
    output logic [CHANNELS-1:0]          overflow
);
    import button_bank_pkg::*;

    localparam int             RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int             RW         = width_for(RMAX - 1);
    localparam logic [RW-1:0]  DELAY_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RATE_LOAD  = RW'(REPEAT_RATE - 1);

    logic w_rise_en;
    logic w_fall_en;
    logic w_rep_ok;

    assign w_rise_en = (edge_mode == EDGE_RISE) || (edge_mode == EDGE_ANY);
    assign w_fall_en = (edge_mode == EDGE_FALL) || (edge_mode == EDGE_ANY);
    assign w_rep_ok  = (edge_mode != EDGE_OFF);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic                w_deb;
        logic                w_rise;
        logic                w_fall;
        logic                w_rep_hit;
        logic                w_pulse;
        logic                r_deb_prev;
        logic [RW-1:0]       r_rep_timer;
        logic [CNT_BITS-1:0] r_cnt;
        logic                r_ovf;

        debounce_fsm #(
            .DEB_TICKS (DEB_TICKS)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .i_noisy (noisy_in[g]),
            .o_deb   (w_deb)
        );

        assign w_rise    = w_deb & ~r_deb_prev;
        assign w_fall    = ~w_deb & r_deb_prev;
        // The rise cycle itself only arms the repeat timer.
        assign w_rep_hit = w_deb & repeat_en & ~w_rise & (r_rep_timer == '0);
        assign w_pulse   = (w_rise & w_rise_en) | (w_fall & w_fall_en) | (w_rep_hit & w_rep_ok);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_deb_prev  <= 1'b0;
                r_rep_timer <= '0;
                r_cnt       <= '0;
                r_ovf       <= 1'b0;
            end else begin
                r_deb_prev <= w_deb;

                if (w_rise) begin
                    r_rep_timer <= DELAY_LOAD;
                end else if (w_deb && repeat_en) begin
                    if (r_rep_timer == '0) begin
                        r_rep_timer <= RATE_LOAD;
                    end else begin
                        r_rep_timer <= r_rep_timer - 1'b1;
                    end
                end else begin
                    r_rep_timer <= DELAY_LOAD;
                end

                if (clear) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_pulse) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end

        assign deb_out[g]                       = w_deb;
        assign pulse[g]                         = w_pulse;
        assign counts[g*CNT_BITS +: CNT_BITS]   = r_cnt;
        assign overflow[g]                      = r_ovf;
    end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: expected pulse cycles queued at stimulus time,
// matched against observed pulses, plus direct checks of levels, counts and flags.
module tb_button_bank;
    import button_bank_pkg::*;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [1:0] noisy_in  = 2'b00;
    logic [1:0] edge_mode = EDGE_RISE;
    logic       repeat_en = 1'b0;
    logic       clear     = 1'b0;
    logic [1:0] deb_out;
    logic [1:0] pulse;
    logic [7:0] counts;
    logic [1:0] overflow;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;
    int n;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;
    exp_t sb_q[$];

    button_bank #(
        .CHANNELS     (2),
        .CNT_BITS     (4),
        .DEB_TICKS    (4),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .noisy_in  (noisy_in),
        .edge_mode (edge_mode),
        .repeat_en (repeat_en),
        .clear     (clear),
        .deb_out   (deb_out),
        .pulse     (pulse),
        .counts    (counts),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input int ch, input int at);
        exp_t e;
        e.ch  = ch;
        e.cyc = at;
        sb_q.push_back(e);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            if (!reset && pulse[c]) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("unexpected_pulse_ch%0d", c), cyc, -1);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_ch", c, e.ch);
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        check("rst_deb_out", deb_out, 0);
        check("rst_pulse", pulse, 0);
        check("rst_counts", counts, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        tick(2);

        // Clean press on ch0, rising mode; release gives no pulse.
        n = cyc;
        noisy_in[0] = 1'b1;
        expect_pulse(0, n + 7);
        tick(6);
        check("deb_before_edge7", deb_out[0], 0);
        tick(1);
        check("deb_at_edge7", deb_out[0], 1);
        check("pulse_at_edge7", pulse[0], 1);
        check("count_not_yet", counts[3:0], 0);
        tick(1);
        check("pulse_one_cycle", pulse[0], 0);
        check("s1_count", counts[3:0], 1);
        noisy_in[0] = 1'b0;
        tick(12);
        check("s1_release_deb", deb_out[0], 0);
        check("s1_release_count", counts[3:0], 1);

        // Bounce then stable high: a single event.
        do_clear();
        check("clear_count", counts[3:0], 0);
        noisy_in[0] = 1'b1; tick(2);
        noisy_in[0] = 1'b0; tick(2);
        noisy_in[0] = 1'b1; tick(2);
        noisy_in[0] = 1'b0; tick(2);
        noisy_in[0] = 1'b1;
        expect_pulse(0, cyc + 7);
        tick(10);
        check("bounce_count", counts[3:0], 1);
        noisy_in[0] = 1'b0;
        tick(10);

        // Any-edge mode: press and release both count.
        do_clear();
        edge_mode = EDGE_ANY;
        noisy_in[0] = 1'b1;
        expect_pulse(0, cyc + 7);
        tick(10);
        noisy_in[0] = 1'b0;
        expect_pulse(0, cyc + 7);
        tick(10);
        check("any_edge_count", counts[3:0], 2);

        // Auto-repeat: t0, t0+8, t0+11, t0+14, t0+17.
        edge_mode = EDGE_RISE;
        do_clear();
        repeat_en = 1'b1;
        n = cyc;
        noisy_in[0] = 1'b1;
        expect_pulse(0, n + 7);
        expect_pulse(0, n + 15);
        expect_pulse(0, n + 18);
        expect_pulse(0, n + 21);
        expect_pulse(0, n + 24);
        tick(19);
        noisy_in[0] = 1'b0;
        tick(12);
        repeat_en = 1'b0;
        check("repeat_count", counts[3:0], 5);

        // 16 presses on ch1 wrap the counter and set overflow.
        do_clear();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                check("ch1_count_15", counts[7:4], 15);
                check("ch1_ovf_before_wrap", overflow[1], 0);
            end
            noisy_in[1] = 1'b1;
            expect_pulse(1, cyc + 7);
            tick(9);
            noisy_in[1] = 1'b0;
            tick(10);
        end
        check("ch1_wrap_count", counts[7:4], 0);
        check("ch1_overflow", overflow[1], 1);
        check("ch0_overflow_clear", overflow[0], 0);

        // clear coinciding with a pulse wins.
        n = cyc;
        noisy_in[1] = 1'b1;
        expect_pulse(1, n + 7);
        tick(7);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_vs_pulse_count", counts[7:4], 0);
        check("clear_vs_pulse_ovf", overflow[1], 0);
        noisy_in[1] = 1'b0;
        tick(10);

        // Simultaneous presses on both channels.
        n = cyc;
        noisy_in = 2'b11;
        expect_pulse(0, n + 7);
        expect_pulse(1, n + 7);
        tick(10);
        check("simul_ch0", counts[3:0], 1);
        check("simul_ch1", counts[7:4], 1);
        noisy_in = 2'b00;
        tick(10);

        // Mode off with repeat held: nothing counts.
        edge_mode = EDGE_OFF;
        repeat_en = 1'b1;
        noisy_in[0] = 1'b1;
        tick(30);
        check("off_deb_high", deb_out[0], 1);
        noisy_in[0] = 1'b0;
        tick(10);
        check("off_ch0_count", counts[3:0], 1);
        check("off_ch1_count", counts[7:4], 1);
        edge_mode = EDGE_RISE;
        repeat_en = 1'b0;

        // Reset during WAIT1 with the pin held, then normal debounce.
        noisy_in[0] = 1'b1;
        tick(4);
        reset = 1'b1;
        #1;
        check("midrst_deb_out", deb_out, 0);
        check("midrst_pulse", pulse, 0);
        check("midrst_counts", counts, 0);
        check("midrst_overflow", overflow, 0);
        tick(2);
        reset = 1'b0;
        n = cyc;
        expect_pulse(0, n + 7);
        tick(6);
        check("postrst_deb_early", deb_out[0], 0);
        tick(1);
        check("postrst_deb_edge7", deb_out[0], 1);
        tick(2);
        check("postrst_count", counts[3:0], 1);
        noisy_in[0] = 1'b0;
        tick(10);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
